sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
- Shares the single byte-wide SDRAM controller port between two requesters:
  - the CPU port, driven by the memory-mapped SDRAM registers (address/data/WE at ports 0x30–0x34);
  - a video/DMA line-fill engine that reads fixed-length bursts.
- Sequences each access through an issue/guard/wait handshake to the SDRAM controller.
- Video has default priority; a starvation counter guarantees bounded CPU latency.

Parameters:
- BURST, 8, video burst length in bytes (2..255).
- STARVE, 16, CPU wait cycles after which the CPU wins the next arbitration slot.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; level, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req high.
- cpu_address  in  32  byte address.
- cpu_wdata  in  8  write data.
- cpu_rdata  out  8  read data; valid in cpu_ack cycle, held until the next CPU read completes.
- cpu_ack  out  1  one-cycle completion pulse.
- vid_start  in  1  one-cycle burst start pulse.
- vid_address  in  32  burst base address; sampled with vid_start.
- vid_rdata  out  8  burst byte.
- vid_valid  out  1  one-cycle pulse per burst byte.
- vid_done  out  1  one-cycle pulse with the last vid_valid.
- vid_overrun  out  1  sticky; set when vid_start arrives while a burst is pending or active; cleared only by reset.
- busy  out  1  state != IDLE or a video burst is pending.
- mem_address  out  32  SDRAM controller address.
- mem_wdata  out  8  write data.
- mem_we  out  1  write enable for the issued access.
- mem_req  out  1  one-cycle access strobe.
- mem_rdata  in  8  read data; valid when mem_ready returns high.
- mem_ready  in  1  controller idle / previous access complete.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE; owner=CPU; beat=0; starve=0; vid_pending=0; vid_overrun=0.
  - All outputs 0.
  - Any in-flight SDRAM access is abandoned; no ack or valid is generated for it.
- vid_start handling:
  - If no burst is pending or active: sets vid_pending and latches vid_base=vid_address.
  - Otherwise: ignored, and vid_overrun is set.
- Starvation counter (starve, 8-bit, saturating at STARVE):
  - Increments each cycle cpu_req=1 and owner is not CPU, or state=IDLE.
  - Clears in the cpu_ack cycle.
- States: IDLE, ISSUE, GUARD, WAIT. The owner register selects CPU or VID.
- IDLE:
  - A CPU request is eligible only when cpu_req=1 and cpu_ack=0, so an acked request is not regranted in its ack cycle.
  - If vid_pending and (no eligible CPU request, or starve<STARVE): owner=VID, go ISSUE.
  - Else if an eligible CPU request exists: owner=CPU, go ISSUE.
- ISSUE:
  - mem_address/mem_we/mem_wdata are driven from the owner; they are registered on entry and held stable through WAIT.
  - VID uses address vid_base+beat (32-bit wrap) and we=0.
  - mem_req=1 only in a cycle with mem_ready=1; the state then moves to GUARD. Otherwise the state stays in ISSUE with mem_req=0.
- GUARD: exactly one cycle; mem_ready is ignored (controller drop latency). Go WAIT.
- WAIT: when mem_ready=1, capture mem_rdata.
  - CPU owner: next cycle cpu_ack=1 and cpu_rdata updated (reads only; writes leave cpu_rdata unchanged). Go IDLE.
  - VID owner: next cycle vid_valid=1 with vid_rdata; beat increments.
    - If beat was BURST-1: vid_done=1 with that vid_valid; beat=0; vid_pending=0; go IDLE.
    - Else if cpu_req=1 and starve>=STARVE: insert the CPU access. Set owner=CPU and go ISSUE; after that access completes, go directly to ISSUE with owner=VID at the saved beat.
    - Else stay owner=VID and go ISSUE for the next beat.
- Latency:
  - Minimum from cpu_req to cpu_ack with mem_ready held high is 4 cycles (IDLE, ISSUE, GUARD, WAIT, then ack).
  - Minimum video beat period is 3 cycles.
- Withdrawn CPU request:
  - cpu_req dropped before ISSUE: no access is performed.
  - cpu_req dropped after ISSUE: the access completes and cpu_ack still pulses.
- At most one SDRAM access is outstanding at any time.

Test Plan:
- CPU read, mem_ready high, mem returns 0xA5 → mem_req one pulse with mem_we=0, cpu_ack 4 cycles after cpu_req, cpu_rdata=0xA5, busy low afterwards.
- vid_start with vid_address=0xFFFFFFFE, BURST=8 → mem_address sequence FFFFFFFE, FFFFFFFF, 0, 1 … 5; 8 vid_valid pulses; vid_done coincides with the 8th.
- cpu_req and vid_start in the same IDLE cycle, starve=0 → video burst granted first; CPU is inserted mid-burst once starve reaches 16, then the burst resumes at the saved beat with no bytes lost or duplicated.
- mem_ready held low 5 cycles in ISSUE → mem_req stays 0 until ready; exactly one mem_req pulse; mem_address stable throughout.
- Second vid_start during an active burst → ignored, vid_overrun=1, still only 8 beats delivered.
- reset_n pulsed low in WAIT of a CPU write → immediate IDLE, all outputs 0, no cpu_ack; a fresh cpu_req afterwards completes normally.

Source files
------------

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares the byte-wide SDRAM controller port between the CPU
// register interface and a video line-fill engine that reads fixed bursts.
// Each access is sequenced as ISSUE -> GUARD -> WAIT. Video has default
// priority, and a saturating starvation counter bounds how long the CPU waits.
module sdram_arbiter #(
    parameter int BURST  = 8,   // video burst length in bytes (2..255)
    parameter int STARVE = 16   // CPU wait cycles before it wins a slot
) (
    input  logic        clock,
    input  logic        reset_n,
    // CPU port
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_address,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    // video burst port
    input  logic        vid_start,
    input  logic [31:0] vid_address,
    output logic [7:0]  vid_rdata,
    output logic        vid_valid,
    output logic        vid_done,
    output logic        vid_overrun,
    output logic        busy,
    // SDRAM controller port
    output logic [31:0] mem_address,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_req,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready
);

    localparam logic [7:0] BEAT_LAST  = 8'(BURST - 1);
    localparam logic [7:0] STARVE_MAX = 8'(STARVE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_GUARD,
        ST_WAIT
    } state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_VID
    } owner_t;

    state_t      state;
    owner_t      owner;
    logic [7:0]  beat;
    logic [7:0]  starve;
    logic        vid_pending;
    logic [31:0] vid_base;

    logic        vid_accept;
    logic        vid_avail;
    logic [31:0] base_eff;
    logic        cpu_eligible;
    logic        cpu_starved;

    // Video byte address for a given beat; wraps naturally at 32 bits.
    function automatic logic [31:0] vid_addr(input logic [31:0] base,
                                             input logic [7:0]  b);
        return base + {24'd0, b};
    endfunction

    // Arbitration qualifiers. A vid_start accepted this cycle already counts as
    // pending, so a simultaneous CPU request does not jump ahead of it.
    always_comb begin
        vid_accept   = vid_start && !vid_pending;
        vid_avail    = vid_pending || vid_accept;
        base_eff     = vid_pending ? vid_base : vid_address;
        cpu_eligible = cpu_req && !cpu_ack;
        cpu_starved  = (starve >= STARVE_MAX);
    end

    // NOTE: mem_req is combinational on mem_ready so the strobe lands in the
    // very cycle the controller reports idle; a registered strobe would fire a
    // cycle late, after the controller may already have become busy again.
    assign mem_req = (state == ST_ISSUE) && mem_ready;
    assign busy    = (state != ST_IDLE) || vid_pending;

    // Access sequencer, arbitration, burst tracking and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            owner       <= OWN_CPU;
            beat        <= 8'd0;
            starve      <= 8'd0;
            vid_pending <= 1'b0;
            vid_base    <= 32'd0;
            vid_overrun <= 1'b0;
            cpu_rdata   <= 8'd0;
            cpu_ack     <= 1'b0;
            vid_rdata   <= 8'd0;
            vid_valid   <= 1'b0;
            vid_done    <= 1'b0;
            mem_address <= 32'd0;
            mem_wdata   <= 8'd0;
            mem_we      <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low every cycle and are raised only
            // by the branch that completes an access, which keeps them exactly
            // one cycle wide without any clearing logic.
            cpu_ack   <= 1'b0;
            vid_valid <= 1'b0;
            vid_done  <= 1'b0;

            // A burst is either taken on or flagged as an overrun.
            if (vid_start) begin
                if (vid_pending) begin
                    vid_overrun <= 1'b1;
                end else begin
                    vid_pending <= 1'b1;
                    vid_base    <= vid_address;
                end
            end

            // CPU wait accounting, saturating at STARVE.
            if (cpu_ack) begin
                starve <= 8'd0;
            end else if (cpu_req && (owner != OWN_CPU || state == ST_IDLE)
                         && starve < STARVE_MAX) begin
                starve <= starve + 8'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (vid_avail && (!cpu_eligible || !cpu_starved)) begin
                        owner       <= OWN_VID;
                        mem_address <= vid_addr(base_eff, beat);
                        mem_we      <= 1'b0;
                        mem_wdata   <= 8'd0;
                        state       <= ST_ISSUE;
                    end else if (cpu_eligible) begin
                        owner       <= OWN_CPU;
                        mem_address <= cpu_address;
                        mem_we      <= cpu_we;
                        mem_wdata   <= cpu_wdata;
                        state       <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (mem_ready) begin
                        state <= ST_GUARD;
                    end
                end

                // The controller needs a cycle to drop mem_ready after a strobe.
                ST_GUARD: begin
                    state <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (mem_ready) begin
                        if (owner == OWN_CPU) begin
                            cpu_ack <= 1'b1;
                            if (!mem_we) begin
                                cpu_rdata <= mem_rdata;
                            end
                            // A non-zero beat with a burst pending means this
                            // CPU access was inserted mid-burst: resume video.
                            if (vid_pending && beat != 8'd0) begin
                                owner       <= OWN_VID;
                                mem_address <= vid_addr(vid_base, beat);
                                mem_we      <= 1'b0;
                                mem_wdata   <= 8'd0;
                                state       <= ST_ISSUE;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            vid_valid <= 1'b1;
                            vid_rdata <= mem_rdata;
                            if (beat == BEAT_LAST) begin
                                vid_done    <= 1'b1;
                                beat        <= 8'd0;
                                vid_pending <= 1'b0;
                                state       <= ST_IDLE;
                            end else begin
                                beat <= beat + 8'd1;
                                if (cpu_req && cpu_starved) begin
                                    owner       <= OWN_CPU;
                                    mem_address <= cpu_address;
                                    mem_we      <= cpu_we;
                                    mem_wdata   <= cpu_wdata;
                                end else begin
                                    mem_address <= vid_addr(vid_base, beat + 8'd1);
                                    mem_we      <= 1'b0;
                                    mem_wdata   <= 8'd0;
                                end
                                state <= ST_ISSUE;
                            end
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: CPU read latency, wrapping video burst,
// CPU insertion under starvation, mem_ready back-pressure, overrun, and reset
// during an access. The SDRAM model returns address[7:0] ^ 8'h5A.
module tb_sdram_arbiter;

    localparam int BURST  = 8;
    localparam int STARVE = 16;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_address = 32'd0;
    logic [7:0]  cpu_wdata = 8'd0;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        vid_start = 1'b0;
    logic [31:0] vid_address = 32'd0;
    logic [7:0]  vid_rdata;
    logic        vid_valid;
    logic        vid_done;
    logic        vid_overrun;
    logic        busy;
    logic [31:0] mem_address;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_req;
    logic [7:0]  mem_rdata;
    logic        mem_ready = 1'b1;

    sdram_arbiter #(.BURST(BURST), .STARVE(STARVE)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_address (cpu_address),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_ack     (cpu_ack),
        .vid_start   (vid_start),
        .vid_address (vid_address),
        .vid_rdata   (vid_rdata),
        .vid_valid   (vid_valid),
        .vid_done    (vid_done),
        .vid_overrun (vid_overrun),
        .busy        (busy),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_req     (mem_req),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready)
    );

    always #5 clock = ~clock;

    // SDRAM data model.
    assign mem_rdata = mem_address[7:0] ^ 8'h5A;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clock) cyc++;

    // Event log, sampled on the falling edge.
    logic [31:0] req_q[$];
    logic [7:0]  vbyte_q[$];
    int          vcyc_q[$];
    int          ack_cnt = 0;
    int          done_cnt = 0;
    int          done_idx = 0;
    logic        last_we = 1'b0;

    always @(negedge clock) begin
        if (reset_n) begin
            if (mem_req) begin
                req_q.push_back(mem_address);
                last_we = mem_we;
            end
            if (vid_valid) begin
                vbyte_q.push_back(vid_rdata);
                vcyc_q.push_back(cyc);
            end
            if (vid_done) begin
                done_cnt++;
                done_idx = vbyte_q.size();
            end
            if (cpu_ack) ack_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_log();
        req_q.delete();
        vbyte_q.delete();
        vcyc_q.delete();
        ack_cnt  = 0;
        done_cnt = 0;
        done_idx = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_address"}, mem_address, 32'd0);
        check({tag, "_ctrl"}, {25'd0, cpu_ack, vid_valid, vid_done, vid_overrun,
                               busy, mem_req, mem_we}, 32'd0);
        check({tag, "_data"}, {8'd0, cpu_rdata, vid_rdata, mem_wdata}, 32'd0);
    endtask

    // Waits up to max_cyc cycles for cpu_ack, dropping cpu_req on it.
    task automatic wait_ack(input int max_cyc, input int t0, output int lat);
        lat = -1;
        for (int i = 0; i < max_cyc; i++) begin
            step();
            if (cpu_ack) begin
                lat     = cyc - t0;
                cpu_req = 1'b0;
                break;
            end
        end
    endtask

    // Waits up to max_cyc cycles for vid_done.
    task automatic wait_done(input int max_cyc, output int seen);
        seen = 0;
        for (int i = 0; i < max_cyc; i++) begin
            step();
            if (vid_done) begin
                seen = 1;
                break;
            end
        end
    endtask

    int t0;
    int lat;
    int seen;
    int ack_lat;
    int done_lat;

    initial begin
        // ---- reset state ----
        repeat (2) step();
        check_reset_outputs("rst");
        reset_n = 1'b1;
        step();
        clear_log();

        // ---- 1: CPU read, mem_ready high, data 0xA5 ----
        t0          = cyc;
        cpu_address = 32'h0000_10FF;
        cpu_we      = 1'b0;
        cpu_req     = 1'b1;
        wait_ack(20, t0, lat);
        check("t1_latency", lat, 4);
        check("t1_rdata", cpu_rdata, 8'hA5);
        check("t1_busy", busy, 1'b0);
        step();
        check("t1_req_count", req_q.size(), 1);
        check("t1_req_addr", req_q[0], 32'h0000_10FF);
        check("t1_req_we", last_we, 1'b0);
        check("t1_ack_count", ack_cnt, 1);

        // ---- 2: wrapping video burst ----
        clear_log();
        vid_address = 32'hFFFF_FFFE;
        vid_start   = 1'b1;
        step();
        vid_start = 1'b0;
        wait_done(60, seen);
        check("t2_done_seen", seen, 1);
        step();
        check("t2_beats", vbyte_q.size(), BURST);
        check("t2_req_count", req_q.size(), BURST);
        check("t2_done_count", done_cnt, 1);
        check("t2_done_with_last", done_idx, BURST);
        check("t2_beat_period", vcyc_q[1] - vcyc_q[0], 3);
        for (int i = 0; i < BURST; i++) begin
            logic [31:0] a;
            a = 32'hFFFF_FFFE + 32'(i);
            check($sformatf("t2_addr%0d", i), req_q[i], a);
            check($sformatf("t2_byte%0d", i), vbyte_q[i], a[7:0] ^ 8'h5A);
        end
        check("t2_busy", busy, 1'b0);

        // ---- 3: simultaneous CPU and video, CPU inserted when starved ----
        clear_log();
        t0          = cyc;
        cpu_address = 32'h2000_0040;
        cpu_we      = 1'b0;
        cpu_req     = 1'b1;
        vid_address = 32'h0000_0100;
        vid_start   = 1'b1;
        step();
        vid_start = 1'b0;
        ack_lat   = -1;
        done_lat  = -1;
        for (int i = 0; i < 80; i++) begin
            if (cpu_ack) begin
                ack_lat = cyc - t0;
                cpu_req = 1'b0;
            end
            if (vid_done) begin
                done_lat = cyc - t0;
                break;
            end
            step();
        end
        step();
        check("t3_ack_cycle", ack_lat, 22);
        check("t3_done_cycle", done_lat, 28);
        check("t3_req_count", req_q.size(), BURST + 1);
        check("t3_video_first", req_q[0], 32'h0000_0100);
        check("t3_cpu_slot", req_q[6], 32'h2000_0040);
        check("t3_resume6", req_q[7], 32'h0000_0106);
        check("t3_resume7", req_q[8], 32'h0000_0107);
        check("t3_beats", vbyte_q.size(), BURST);
        for (int i = 0; i < BURST; i++) begin
            logic [7:0] b;
            b = 8'(i);
            check($sformatf("t3_byte%0d", i), vbyte_q[i], b ^ 8'h5A);
        end
        check("t3_gap", vcyc_q[6] - vcyc_q[5], 6);
        check("t3_rdata", cpu_rdata, 8'h1A);
        check("t3_ack_count", ack_cnt, 1);

        // ---- 4: mem_ready low for 5 ISSUE cycles, CPU write ----
        clear_log();
        t0          = cyc;
        cpu_address = 32'h3000_0004;
        cpu_we      = 1'b1;
        cpu_wdata   = 8'h99;
        cpu_req     = 1'b1;
        mem_ready   = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            check($sformatf("t4_noreq%0d", i), mem_req, 1'b0);
            check($sformatf("t4_addr%0d", i), mem_address, 32'h3000_0004);
        end
        step();
        mem_ready = 1'b1;
        #1;
        check("t4_req_on_ready", mem_req, 1'b1);
        wait_ack(20, t0, lat);
        check("t4_latency", lat, 9);
        check("t4_wdata", mem_wdata, 8'h99);
        check("t4_rdata_kept", cpu_rdata, 8'h1A);
        step();
        check("t4_req_count", req_q.size(), 1);
        check("t4_req_we", last_we, 1'b1);

        // ---- 5: second vid_start during a burst ----
        clear_log();
        vid_address = 32'h0000_0040;
        vid_start   = 1'b1;
        step();
        vid_start = 1'b0;
        repeat (4) step();
        check("t5_no_overrun_yet", vid_overrun, 1'b0);
        vid_address = 32'h0000_9000;
        vid_start   = 1'b1;
        step();
        vid_start = 1'b0;
        check("t5_overrun", vid_overrun, 1'b1);
        wait_done(60, seen);
        check("t5_done_seen", seen, 1);
        repeat (6) step();
        check("t5_beats", vbyte_q.size(), BURST);
        check("t5_req_count", req_q.size(), BURST);
        check("t5_last_addr", req_q[BURST-1], 32'h0000_0047);
        check("t5_done_count", done_cnt, 1);
        check("t5_idle", busy, 1'b0);
        check("t5_overrun_sticky", vid_overrun, 1'b1);

        // ---- 6: reset during WAIT of a CPU write ----
        clear_log();
        t0          = cyc;
        cpu_address = 32'h0000_0050;
        cpu_we      = 1'b1;
        cpu_wdata   = 8'h3C;
        cpu_req     = 1'b1;
        repeat (3) step();
        check("t6_in_access", {busy, mem_we}, 2'b11);
        reset_n = 1'b0;
        cpu_req = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        repeat (2) step();
        reset_n = 1'b1;
        repeat (6) step();
        check("t6_no_ack", ack_cnt, 0);
        t0          = cyc;
        cpu_address = 32'h0000_00FF;
        cpu_we      = 1'b0;
        cpu_req     = 1'b1;
        wait_ack(20, t0, lat);
        check("t6_fresh_latency", lat, 4);
        check("t6_fresh_rdata", cpu_rdata, 8'hA5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global bound on run time.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
